// File: rtl/mipi_pkg.sv
// Shared RAW10 constants and the word-phase type used by the depacker.
package mipi_pkg;

  localparam logic [5:0] RAW10_DT     = 6'h2B;
  localparam int         GROUP_BYTES  = 5;
  localparam int         GROUP_PIXELS = 4;
  localparam int         PIX_W        = 10;

  // Position of the incoming word inside a two-group (5-word) cycle.
  typedef enum logic [2:0] {
    PH_W0 = 3'd0,
    PH_W1 = 3'd1,
    PH_W2 = 3'd2,
    PH_W3 = 3'd3,
    PH_W4 = 3'd4
  } phase_t;

  function automatic phase_t phase_next(input phase_t p);
    return (p == PH_W4) ? PH_W0 : phase_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/raw10_group_unpack.sv
// Combinational split of one RAW10 group (four MSB bytes + one LSB byte)
// into four 10-bit pixels; pixel i lands in pix[10*i +: 10].
module raw10_group_unpack
  import mipi_pkg::*;
(
  input  logic [31:0]             msb,
  input  logic [7:0]              lsb,
  output logic [4*PIX_W-1:0]      pix
);

  // Each pixel is its MSB byte with its two LSBs taken from the shared byte.
  always_comb begin
    pix = '0;
    for (int i = 0; i < GROUP_PIXELS; i++) begin
      pix[i*PIX_W +: PIX_W] = {msb[i*8 +: 8], lsb[i*2 +: 2]};
    end
  end

endmodule

// File: rtl/mipi_raw10_depacker.sv
// RAW10 depacker: turns the 2-lane 16-bit payload stream into two 10-bit
// pixels per beat, regenerates line-end / frame-sync markers, counts lines
// and flags truncated groups or wrong line lengths.
//
// Streaming handshake: there is no ready. A word is consumed on every rising
// edge where I_Unpacket_Vaild is high and I_Unpacket_V_sync is low; an output
// beat is valid exactly in the cycles where O_Pixel_Vaild is high, and
// O_Pixel_Data is forced to zero otherwise. A line ends on the first cycle
// valid is low after a consumed word.
module mipi_raw10_depacker
  import mipi_pkg::*;
#(
  parameter int Lane_Num = 2,
  parameter int Image_W  = 1920,
  parameter int Image_H  = 1080
) (
  input  logic                    I_CLK,
  input  logic                    I_Rst_n,
  input  logic [8*Lane_Num-1:0]   I_Unpacket_Data,
  input  logic                    I_Unpacket_Vaild,
  input  logic                    I_Unpacket_V_sync,
  output logic [19:0]             O_Pixel_Data,
  output logic                    O_Pixel_Vaild,
  output logic                    O_Pixel_H_end,
  output logic                    O_Pixel_V_sync,
  output logic                    O_Pixel_Err,
  output logic [11:0]             O_Line_Cnt,
  output logic [2:0]              dbg_phase
);

  localparam logic [11:0] LINE_PIX = 12'(Image_W);
  localparam logic [12:0] LAST_OK  = 13'(Image_H);

  logic [15:0] word;
  logic        sync;
  logic        accept;
  logic        line_end;

  // Registered state.
  phase_t      phase_q, phase_n;
  logic        pend_q, pend_n;
  logic [19:0] pend_data_q, pend_data_n;
  logic [31:0] hold_a_q, hold_a_n;   // {P4h,P3h,P2h,P1h}
  logic [23:0] hold_b_q, hold_b_n;   // {P7h,P6h,P5h}
  logic [7:0]  l1_q, l1_n;
  logic        acc_q;
  logic [11:0] pix_cnt_q, pix_cnt_n;
  logic [11:0] line_cnt_q, line_cnt_n;

  // Next-cycle output values.
  logic        beat_v;
  logic [19:0] beat_data;
  logic        h_end;
  logic        err;

  // Unpacker operand selection.
  logic [31:0] unp_msb;
  logic [7:0]  unp_lsb;
  logic [39:0] unp_pix;

  assign word      = I_Unpacket_Data[15:0];
  assign sync      = I_Unpacket_V_sync;
  assign accept    = I_Unpacket_Vaild & ~sync;
  assign line_end  = acc_q & ~I_Unpacket_Vaild & ~sync;
  assign O_Line_Cnt = line_cnt_q;
  assign dbg_phase  = phase_q;

  // Pick which held group the single unpacker decodes this cycle.
  always_comb begin
    unp_msb = hold_a_q;
    unp_lsb = l1_q;
    if (phase_q == PH_W2) begin
      unp_lsb = word[7:0];
    end else if (phase_q == PH_W4) begin
      unp_msb = {word[7:0], hold_b_q};
      unp_lsb = word[15:8];
    end
  end

  raw10_group_unpack u_unpack (
    .msb (unp_msb),
    .lsb (unp_lsb),
    .pix (unp_pix)
  );

  // Phase sequencing, byte capture, beat generation, line-end and error logic.
  always_comb begin
    phase_n     = phase_q;
    pend_n      = pend_q;
    pend_data_n = pend_data_q;
    hold_a_n    = hold_a_q;
    hold_b_n    = hold_b_q;
    l1_n        = l1_q;
    pix_cnt_n   = pix_cnt_q;
    line_cnt_n  = line_cnt_q;
    beat_v      = 1'b0;
    beat_data   = '0;
    h_end       = 1'b0;
    err         = 1'b0;

    if (sync) begin
      // Frame start drops everything in flight, including a same-cycle word.
      phase_n    = PH_W0;
      pend_n     = 1'b0;
      pix_cnt_n  = '0;
      line_cnt_n = '0;
    end else begin
      // The P7,P8 beat always follows the P5,P6 beat by one cycle.
      if (pend_q) begin
        beat_v    = 1'b1;
        beat_data = pend_data_q;
        pend_n    = 1'b0;
      end

      if (accept) begin
        phase_n = phase_next(phase_q);
        case (phase_q)
          PH_W0: hold_a_n[15:0] = word;
          PH_W1: hold_a_n[31:16] = word;
          PH_W2: begin
            l1_n           = word[7:0];
            hold_b_n[7:0]  = word[15:8];
            beat_v         = 1'b1;
            beat_data      = unp_pix[19:0];
          end
          PH_W3: begin
            hold_b_n[23:8] = word;
            beat_v         = 1'b1;
            beat_data      = unp_pix[39:20];
          end
          PH_W4: begin
            beat_v      = 1'b1;
            beat_data   = unp_pix[19:0];
            pend_n      = 1'b1;
            pend_data_n = unp_pix[39:20];
          end
          default: phase_n = PH_W0;
        endcase
      end

      if (beat_v) begin
        pix_cnt_n = pix_cnt_q + 12'd2;
      end

      if (line_end) begin
        pix_cnt_n = '0;
        phase_n   = PH_W0;
        if (phase_q != PH_W0) begin
          // Partial group: discard it and flag it, no line-end beat.
          err = 1'b1;
        end else if (pend_q) begin
          h_end = 1'b1;
          if (pix_cnt_q + 12'd2 != LINE_PIX) begin
            err = 1'b1;
          end
          if (line_cnt_q != 12'hFFF) begin
            line_cnt_n = line_cnt_q + 12'd1;
            if ({1'b0, line_cnt_q} == LAST_OK) begin
              err = 1'b1;
            end
          end
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      phase_q        <= PH_W0;
      pend_q         <= 1'b0;
      pend_data_q    <= '0;
      hold_a_q       <= '0;
      hold_b_q       <= '0;
      l1_q           <= '0;
      acc_q          <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      O_Pixel_Data   <= '0;
      O_Pixel_Vaild  <= 1'b0;
      O_Pixel_H_end  <= 1'b0;
      O_Pixel_V_sync <= 1'b0;
      O_Pixel_Err    <= 1'b0;
    end else begin
      phase_q        <= phase_n;
      pend_q         <= pend_n;
      pend_data_q    <= pend_data_n;
      hold_a_q       <= hold_a_n;
      hold_b_q       <= hold_b_n;
      l1_q           <= l1_n;
      acc_q          <= accept;
      pix_cnt_q      <= pix_cnt_n;
      line_cnt_q     <= line_cnt_n;
      O_Pixel_Data   <= beat_v ? beat_data : 20'd0;
      O_Pixel_Vaild  <= beat_v;
      O_Pixel_H_end  <= h_end;
      O_Pixel_V_sync <= sync;
      O_Pixel_Err    <= err;
    end
  end

endmodule
